// File: rtl/io_bus_pkg.sv
// Shared state encoding and constants for the I/O bus cycle master.
package io_bus_pkg;
  localparam int DATA_W          = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } io_state_t;
endpackage

// File: rtl/io_timeout_ctr.sv
// Strobe-phase watchdog: cleared while in SETUP, counts STROBE cycles, expired is high
// during the TIMEOUT-th strobe cycle. Zero latency on expired; no backpressure.
module io_timeout_ctr
  import io_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/io_cycle_master.sv
// I/O bus cycle initiator: REQ -> SETUP -> STROBE (until IOACK_n or timeout) -> HOLD (DONE/BERR).
// All outputs registered; REQ accepted only in IDLE. IO_TIMEOUT_EN builds the timeout/BERR path.
module io_cycle_master
  import io_bus_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [ADDR_W-1:0] MA,
  output logic              CS5,
  output logic              RDIO_n,
  output logic              WRIO_n,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOE,
  input  logic [DATA_W-1:0] DIN,
  input  logic              IOACK_n,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              BERR
);
  io_state_t state;
  logic      we_q;
  logic      expired;

`ifdef IO_TIMEOUT_EN
  io_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (state == SETUP),
    .en     (state == STROBE),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      MA     <= '0;
      CS5    <= 1'b0;
      RDIO_n <= 1'b1;
      WRIO_n <= 1'b1;
      DOUT   <= '0;
      DOE    <= 1'b0;
      RDATA  <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      BERR   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      BERR <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            MA    <= ADDR;
            we_q  <= WE;
            DOUT  <= WDATA;
            CS5   <= 1'b1;
            DOE   <= WE;
            BUSY  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          RDIO_n <= we_q;
          WRIO_n <= !we_q;
          state  <= STROBE;
        end
        STROBE: begin
          // An ack on the expiry edge takes priority over the timeout.
          if (!IOACK_n) begin
            if (!we_q) RDATA <= DIN;
            RDIO_n <= 1'b1;
            WRIO_n <= 1'b1;
            DONE   <= 1'b1;
            state  <= HOLD;
          end else if (expired) begin
            RDIO_n <= 1'b1;
            WRIO_n <= 1'b1;
            DONE   <= 1'b1;
            BERR   <= 1'b1;
            state  <= HOLD;
          end
        end
        HOLD: begin
          CS5   <= 1'b0;
          DOE   <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_cycle_master.sv
// Bench for io_cycle_master: directed vector table, timeout/abort sequences, randomized cycles vs. model.
module tb_io_cycle_master;
  localparam int AW = 15;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          REQ = 1'b0;
  logic          WE = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic [7:0]    WDATA = '0;
  logic [AW-1:0] MA;
  logic          CS5, RDIO_n, WRIO_n, DOE, BUSY, DONE, BERR;
  logic [7:0]    DOUT, RDATA;
  logic [7:0]    DIN = '0;
  logic          IOACK_n = 1'b1;

  int tests = 0;
  int fails = 0;

  io_cycle_master #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .MA(MA), .CS5(CS5), .RDIO_n(RDIO_n), .WRIO_n(WRIO_n), .DOUT(DOUT), .DOE(DOE),
    .DIN(DIN), .IOACK_n(IOACK_n), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE), .BERR(BERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    din;
    int            ack_at;   // strobe cycle on which IOACK_n is low; 0 = never
    bit            stale;    // IOACK_n held low through REQ and SETUP
    bit            req_hold; // REQ kept high while BUSY
    int            exp_len;
    bit            exp_berr;
    logic [7:0]    exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: a cycle ends on the ack if it arrives within the timeout window, else it times out.
  function automatic void model(input logic we, input int ack_at, input logic [7:0] din,
                                inout logic [7:0] rd, output int len, output bit berr);
`ifdef IO_TIMEOUT_EN
    if (ack_at >= 1 && ack_at <= TO) begin
      len = ack_at; berr = 1'b0;
      if (!we) rd = din;
    end else begin
      len = TO; berr = 1'b1;
    end
`else
    len = ack_at; berr = 1'b0;
    if (!we) rd = din;
`endif
  endfunction

  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                         input logic [7:0] din, input int ack_at, input bit stale,
                         input bit req_hold, input int limit,
                         output int len, output bit done_seen, output bit berr_seen,
                         output logic [7:0] rdata_seen, output bit ended);
    len = 0; done_seen = 0; berr_seen = 0; rdata_seen = '0; ended = 0;
    @(negedge CLK);
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_cs5", CS5, 1'b0);
    chk("idle_doe", DOE, 1'b0);
    chk("idle_done", DONE, 1'b0);
    chk("idle_strobes", {RDIO_n, WRIO_n}, 2'b11);
    REQ = 1'b1; WE = we; ADDR = addr; WDATA = wdata;
    IOACK_n = stale ? 1'b0 : 1'b1;
    @(negedge CLK);
    REQ = req_hold; WE = ~we; ADDR = ~addr; WDATA = ~wdata;
    chk("setup_busy", BUSY, 1'b1);
    chk("setup_cs5", CS5, 1'b1);
    chk("setup_ma", MA, addr);
    chk("setup_doe", DOE, we);
    chk("setup_strobes", {RDIO_n, WRIO_n}, 2'b11);
    if (we) chk("setup_dout", DOUT, wdata);
    for (int c = 0; c < limit && !ended; c++) begin
      @(negedge CLK);
      if ((we && !WRIO_n) || (!we && !RDIO_n)) begin
        len++;
        chk("strobe_other", we ? RDIO_n : WRIO_n, 1'b1);
        chk("strobe_cs5", CS5, 1'b1);
        chk("strobe_ma", MA, addr);
        chk("strobe_doe", DOE, we);
        chk("strobe_done", DONE, 1'b0);
        IOACK_n = (len == ack_at) ? 1'b0 : 1'b1;
        DIN = (len == ack_at) ? din : 8'($urandom);
      end else begin
        ended = 1; done_seen = DONE; berr_seen = BERR; rdata_seen = RDATA;
        chk("hold_strobes", {RDIO_n, WRIO_n}, 2'b11);
        chk("hold_cs5", CS5, 1'b1);
        chk("hold_ma", MA, addr);
        chk("hold_doe", DOE, we);
        chk("hold_busy", BUSY, 1'b1);
        if (we) chk("hold_dout", DOUT, wdata);
        IOACK_n = 1'b1; REQ = 1'b0;
      end
    end
  endtask

  task automatic do_vec(input string nm, input vec_t v, input int limit);
    int len; bit dn, be, ended; logic [7:0] rd;
    run_txn(v.we, v.addr, v.wdata, v.din, v.ack_at, v.stale, v.req_hold, limit,
            len, dn, be, rd, ended);
    chk({nm, "_ended"}, ended, 1'b1);
    chk({nm, "_len"}, len, v.exp_len);
    chk({nm, "_done"}, dn, 1'b1);
    chk({nm, "_berr"}, be, v.exp_berr);
    chk({nm, "_rdata"}, rd, v.exp_rdata);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [7:0] prev;
    int len; bit dn, be, ended; logic [7:0] rd;

    tbl[0] = '{1'b0, 15'h0800, 8'h00, 8'hA5, 3, 1'b0, 1'b0, 3, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 15'h3800, 8'h3C, 8'h77, 2, 1'b0, 1'b0, 2, 1'b0, 8'hA5};
    tbl[2] = '{1'b0, 15'h7FFF, 8'h00, 8'h5A, 1, 1'b0, 1'b0, 1, 1'b0, 8'h5A};
    tbl[3] = '{1'b0, 15'h1234, 8'h00, 8'h81, 4, 1'b1, 1'b0, 4, 1'b0, 8'h81};
    tbl[4] = '{1'b0, 15'h0001, 8'hFF, 8'h00, 2, 1'b0, 1'b1, 2, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 15'h2AAA, 8'h55, 8'hC3, 5, 1'b1, 1'b1, 5, 1'b0, 8'h00};

    #2 RESET = 1'b1;
    @(negedge CLK);
    chk("rst_ma", MA, 0);
    chk("rst_cs5", CS5, 1'b0);
    chk("rst_rdio", RDIO_n, 1'b1);
    chk("rst_wrio", WRIO_n, 1'b1);
    chk("rst_dout", DOUT, 0);
    chk("rst_doe", DOE, 1'b0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_berr", BERR, 1'b0);
    RESET = 1'b0;

    for (int i = 0; i < 6; i++) do_vec($sformatf("vec%0d", i), tbl[i], 300);

`ifdef IO_TIMEOUT_EN
    v = '{1'b0, 15'h0100, 8'h00, 8'hEE, 0, 1'b0, 1'b0, TO, 1'b1, 8'h00};
    do_vec("timeout0", v, 300);
    v = '{1'b0, 15'h0200, 8'h00, 8'h42, TO, 1'b0, 1'b0, TO, 1'b0, 8'h42};
    do_vec("race", v, 300);
    v = '{1'b0, 15'h0300, 8'h00, 8'h99, 0, 1'b1, 1'b0, TO, 1'b1, 8'h42};
    do_vec("timeout1", v, 300);
`else
    run_txn(1'b0, 15'h0100, 8'h00, 8'hEE, 0, 1'b0, 1'b0, 1000, len, dn, be, rd, ended);
    chk("notimeout_ended", ended, 1'b0);
    chk("notimeout_busy", BUSY, 1'b1);
    chk("notimeout_berr", BERR, 1'b0);
    chk("notimeout_len", len, 1000);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
`endif

    // Abort: reset in the middle of a read strobe.
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b0; ADDR = 15'h0555; IOACK_n = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_pre_rdio", RDIO_n, 1'b0);
    RESET = 1'b1;
    #1;
    chk("abort_rdio", RDIO_n, 1'b1);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_cs5", CS5, 1'b0);
    chk("abort_done", DONE, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("abort_after_done", DONE, 1'b0);
      chk("abort_after_busy", BUSY, 1'b0);
    end
    chk("abort_rdata", RDATA, 0);

    prev = 8'h00;
    for (int i = 0; i < 40; i++) begin
      int ack, elen; bit eberr;
      logic we_r; logic [AW-1:0] a; logic [7:0] wd, di;
      we_r = 1'($urandom); a = AW'($urandom); wd = 8'($urandom); di = 8'($urandom);
`ifdef IO_TIMEOUT_EN
      ack = $urandom_range(0, TO + 2);
`else
      ack = $urandom_range(1, 12);
`endif
      model(we_r, ack, di, prev, elen, eberr);
      v = '{we_r, a, wd, di, ack, 1'($urandom), 1'($urandom), elen, eberr, prev};
      do_vec($sformatf("rnd%0d", i), v, 300);
    end

    @(negedge CLK);
    chk("final_idle_busy", BUSY, 1'b0);
    chk("final_idle_done", DONE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_cycle_master.md
# io_cycle_master

I/O bus cycle initiator for the 120 CPU board. It turns a single-cycle CPU-side request into a full byte-wide I/O bus cycle: address and chip select, then the /RDIO or /WRIO strobe, a wait for /IOACK from the acknowledge generator, and read-data capture. It ends every cycle with a DONE or bus-error (BERR) completion pulse. It sits between the CPU bus interface logic and the I/O device decode and acknowledge PALs.

## Interface
Parameters:
- ADDR_W, 15: width of the I/O address driven on MA.
- TIMEOUT, 64: number of STROBE cycles without /IOACK before a bus error (range 2..255).

Ports:
- CLK  in  1  board clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  1  start-cycle pulse, sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  ADDR_W  I/O address; sampled with REQ.
- WDATA  in  8  write data; sampled with REQ.
- MA  out  ADDR_W  registered address to the device decode.
- CS5  out  1  I/O space select, active high.
- RDIO_n  out  1  read strobe, active low.
- WRIO_n  out  1  write strobe, active low.
- DOUT  out  8  write data to the I/O data bus.
- DOE  out  1  DOUT output enable.
- DIN  in  8  read data from the I/O data bus.
- IOACK_n  in  1  acknowledge from the responder, active low, synchronous to CLK.
- RDATA  out  8  captured read data; held until the next read completes.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle completion pulse.
- BERR  out  1  one-cycle timeout pulse; coincident with DONE.

## Operation
- **IDLE:** REQ=1 registers ADDR, WE and WDATA, then moves to SETUP.
- **SETUP:** one cycle. MA and CS5=1 are valid. DOE=WE. Strobes stay inactive. Moves to STROBE.
- **STROBE:**
  - RDIO_n=0 for a read, or WRIO_n=0 for a write. The timeout counter clears on entry and increments once per cycle.
  - IOACK_n sampled 0 moves to HOLD. On a read, DIN is captured into RDATA on that same edge.
  - Counter reaching TIMEOUT-1 with no ack moves to HOLD and sets the BERR flag.
- **HOLD:** one cycle. Strobes are inactive. CS5, MA and DOE are held. DONE=1, and BERR=1 if the flag is set. Moves to IDLE, where CS5 and DOE drop.
- **REQ outside IDLE:** ignored. There is no queueing.
- **Ack and timeout on the same edge:** the ack wins. BERR=0 and RDATA is updated.
- **Read data on timeout:** RDATA keeps its previous value.
- **IOACK_n low outside STROBE:** ignored. A stale ack from the previous cycle must not end the next one.

## Timing
- **Reset values:** RESET=1 forces IDLE, MA=0, CS5=0, RDIO_n=1, WRIO_n=1, DOUT=0, DOE=0, RDATA=0, BUSY=0, DONE=0, BERR=0. Reset applies immediately, mid-cycle included. No DONE is issued for an aborted cycle.
- **Output registers:** all outputs are registered. There are no combinational paths from inputs to outputs.
- **Cycle timeline:** REQ is sampled at edge 0. SETUP runs edge 0..1. The strobe is asserted from edge 1. An ack sampled at edge k moves to HOLD, so DONE is high between edge k and edge k+1. BUSY falls at edge k+1.
- **Minimum length:** ack at the first STROBE edge (k=2) gives a total of 3 cycles from REQ to BUSY low.
- **Back-to-back:** the next REQ is accepted at edge k+1.
- **Timeout length:** the strobe is active for exactly TIMEOUT cycles before HOLD.

## Configuration
- **IO_TIMEOUT_EN defined:** the timeout counter and BERR path are present, as described above.
- **IO_TIMEOUT_EN undefined:** STROBE waits indefinitely for IOACK_n. BERR is tied to 0. No counter logic is synthesized. The TIMEOUT parameter is accepted but unused.

## Structure
- **Shared package io_bus_pkg:**
  - state enum (IDLE, SETUP, STROBE, HOLD);
  - DATA_W=8;
  - default TIMEOUT constant.
- **Sub-module io_timeout_ctr:** the counter, with clear, enable and an expired output, instantiated only under IO_TIMEOUT_EN.

## Test plan
- **Read, 2-wait-state responder:** REQ at ADDR=0x0800, WE=0, with IOACK_n low on the 3rd STROBE cycle and DIN=0xA5. Expect RDIO_n low for 3 cycles, RDATA=0xA5, DONE for 1 cycle, BERR=0, WRIO_n held at 1.
- **Write:** WDATA=0x3C at 0x3800. Expect DOUT=0x3C and DOE=1 from SETUP through HOLD, and WRIO_n low until the ack.
- **Timeout:** TIMEOUT=16 and no ack. Expect the strobe active for exactly 16 cycles, then DONE=BERR=1 for 1 cycle, with RDATA unchanged. With IO_TIMEOUT_EN undefined, expect BUSY to stay high after 1000 cycles.
- **Ack/timeout race:** the ack arrives on the expiry edge. Expect BERR=0 and RDATA updated.
- **Abort and back-to-back:** RESET asserted mid-STROBE must release the strobes in the same cycle, with no DONE. A REQ held during BUSY must be ignored. A REQ in the DONE+1 cycle must start a new cycle.
